// File: rtl/sub16_serial.sv
// Bit-serial subtractor, LSB first, one full-subtractor cell.
// Optional signed overflow flag enabled by `define SUB16_OVF_EN.
module sub16_serial #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
`ifdef SUB16_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] d_sh;
  logic             br;
  logic             dbit;
  logic             bo;
  logic             last;

  assign dbit = a_sh[0] ^ b_sh[0] ^ br;
  assign bo   = (~a_sh[0] & b_sh[0])
              | (~(a_sh[0] ^ b_sh[0]) & br);
  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      Diff  <= '0;
      Bout  <= 1'b0;
      cnt   <= '0;
      br    <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      d_sh  <= '0;
`ifdef SUB16_OVF_EN
      Ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sh  <= A;
            b_sh  <= B;
            br    <= Bin;
            cnt   <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          d_sh <= {dbit, d_sh[WIDTH-1:1]};
          br   <= bo;
          cnt  <= cnt + 1'b1;
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            Diff  <= {dbit, d_sh[WIDTH-1:1]};
            Bout  <= bo;
`ifdef SUB16_OVF_EN
            // On the final bit the shifters hold the operand sign bits
            Ovf   <= (a_sh[0] != b_sh[0])
                   && (dbit != a_sh[0]);
`endif
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
